// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage_if
// Purpose  : MEM -> WB instruction handshake bundle.
// Revision : 1.0
// ============================================================================
interface mem_wb_stage_if;
    logic        m_valid;
    logic        m_ready;
    logic        m_reg_write;
    logic [1:0]  m_wb_sel;
    logic [4:0]  m_rd_index;
    logic [31:0] m_alu_result;
    logic [31:0] m_pc_plus4;
    logic [2:0]  m_funct3;

    modport master (
        output m_valid, m_reg_write, m_wb_sel, m_rd_index,
               m_alu_result, m_pc_plus4, m_funct3,
        input  m_ready
    );

    modport slave (
        input  m_valid, m_reg_write, m_wb_sel, m_rd_index,
               m_alu_result, m_pc_plus4, m_funct3,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : RV32I writeback stage: load alignment/extension, RF write port,
//            64-bit retired-instruction counter.
// Revision : 1.0
// ============================================================================
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  m,
    input  logic [31:0]    dm_rdata,
    input  logic           dm_rvalid,
    output logic           wb_en,
    output logic [31:0]    wb_data,
    output logic [4:0]     W_rd_index,
    output logic [63:0]    instret
);

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [4:0]  r_ld_rd;
    logic        r_ld_reg_write;
    logic [2:0]  r_ld_funct3;
    logic [1:0]  r_ld_offset;

    logic        w_ready;
    logic        w_accept;
    logic [31:0] w_sel_value;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_ready   = !rst && (r_state == ST_IDLE);
    assign m.m_ready = w_ready;
    assign w_accept  = m.m_valid && w_ready;

    assign w_sel_value = (m.m_wb_sel == 2'd2) ? m.m_pc_plus4 : m.m_alu_result;

    // Memory returns the whole aligned word; pick the lane from the saved address.
    always_comb begin
        w_byte = dm_rdata[7:0];
        case (r_ld_offset)
            2'd0:    w_byte = dm_rdata[7:0];
            2'd1:    w_byte = dm_rdata[15:8];
            2'd2:    w_byte = dm_rdata[23:16];
            default: w_byte = dm_rdata[31:24];
        endcase
        w_half = r_ld_offset[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (r_ld_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = dm_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            wb_en          <= 1'b0;
            wb_data        <= 32'h0;
            W_rd_index     <= 5'd0;
            instret        <= 64'd0;
            r_ld_rd        <= 5'd0;
            r_ld_reg_write <= 1'b0;
            r_ld_funct3    <= 3'd0;
            r_ld_offset    <= 2'd0;
        end else begin
            wb_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (m.m_wb_sel != 2'd1) begin
                            W_rd_index <= m.m_rd_index;
                            wb_data    <= w_sel_value;
                            wb_en      <= m.m_reg_write && (m.m_rd_index != 5'd0);
                            instret    <= instret + 64'd1;
                        end else begin
                            r_ld_rd        <= m.m_rd_index;
                            r_ld_reg_write <= m.m_reg_write;
                            r_ld_funct3    <= m.m_funct3;
                            r_ld_offset    <= m.m_alu_result[1:0];
                            r_state        <= ST_LOAD_WAIT;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    if (dm_rvalid) begin
                        W_rd_index <= r_ld_rd;
                        wb_data    <= w_load_data;
                        wb_en      <= r_ld_reg_write && (r_ld_rd != 5'd0);
                        instret    <= instret + 64'd1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Randomized scoreboard bench for mem_wb_stage.
// Revision : 1.0
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dm_rdata = 32'h0;
    logic        dm_rvalid = 1'b0;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [4:0]  W_rd_index;
    logic [63:0] instret;

    mem_wb_stage_if ifc ();

    mem_wb_stage dut (
        .clk        (clk),
        .rst        (rst),
        .m          (ifc),
        .dm_rdata   (dm_rdata),
        .dm_rvalid  (dm_rvalid),
        .wb_en      (wb_en),
        .wb_data    (wb_data),
        .W_rd_index (W_rd_index),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_instret = 64'd0;
    logic [36:0] exp_q [$];   // {rd, data}
    bit          mon_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference load semantics: shift the addressed lane down, then extend.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] w);
        logic [31:0] s;
        case (f3)
            3'b000, 3'b100: begin
                s = w >> (8 * off);
                s = s & 32'h0000_00FF;
                if (f3 == 3'b000 && s >= 32'h80) s = s + 32'hFFFF_FF00;
                return s;
            end
            3'b001, 3'b101: begin
                s = w >> (16 * off[1]);
                s = s & 32'h0000_FFFF;
                if (f3 == 3'b001 && s >= 32'h8000) s = s + 32'hFFFF_0000;
                return s;
            end
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("instret", instret, exp_instret);
            if (wb_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: rd=%0d data=%h at %0t", W_rd_index, wb_data, $time);
                end else begin
                    logic [36:0] e;
                    e = exp_q.pop_front();
                    chk("wb_rd", {59'd0, W_rd_index}, {59'd0, e[36:32]});
                    chk("wb_data", {32'd0, wb_data}, {32'd0, e[31:0]});
                end
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        forever begin
            @(negedge clk);
            if (ifc.m_ready === 1'b1) begin
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 64'd1, 64'd0);
                return;
            end
        end
    endtask

    task automatic idle(input int n, input bit spurious);
        ifc.m_valid = 1'b0;
        repeat (n) begin
            dm_rvalid = spurious;
            dm_rdata  = $urandom;
            @(posedge clk);
            #1;
        end
        dm_rvalid = 1'b0;
    endtask

    task automatic issue(input logic rw, input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3,
                         input logic [31:0] rdata, input int lat, input logic [31:0] exp);
        ifc.m_valid      = 1'b1;
        ifc.m_reg_write  = rw;
        ifc.m_wb_sel     = sel;
        ifc.m_rd_index   = rd;
        ifc.m_alu_result = alu;
        ifc.m_pc_plus4   = pc4;
        ifc.m_funct3     = f3;
        dm_rvalid        = 1'($urandom_range(0, 1));
        dm_rdata         = $urandom;
        wait_accept();
        dm_rvalid = 1'b0;
        if (sel != 2'd1) begin
            exp_instret++;
            if (rw && rd != 5'd0) exp_q.push_back({rd, exp});
        end else begin
            ifc.m_valid = 1'b0;
            for (int i = 0; i < lat; i++) begin
                @(negedge clk);
                chk("ready_low_wait", {63'd0, ifc.m_ready}, 64'd0);
                @(posedge clk);
                #1;
            end
            dm_rdata  = rdata;
            dm_rvalid = 1'b1;
            @(negedge clk);
            chk("ready_low_resp", {63'd0, ifc.m_ready}, 64'd0);
            @(posedge clk);
            #1;
            dm_rvalid = 1'b0;
            exp_instret++;
            if (rw && rd != 5'd0) exp_q.push_back({rd, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.m_valid = 1'b0;
        ifc.m_reg_write = 1'b0;
        ifc.m_wb_sel = 2'd0;
        ifc.m_rd_index = 5'd0;
        ifc.m_alu_result = 32'h0;
        ifc.m_pc_plus4 = 32'h0;
        ifc.m_funct3 = 3'd0;
        #12;
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("rst_rd", {59'd0, W_rd_index}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_ready", {63'd0, ifc.m_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;

        issue(1'b1, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 3'd0, 32'h0, 0, 32'h1234_5678);
        idle(2, 1'b0);
        issue(1'b1, 2'd1, 5'd7, 32'h0000_1003, 32'h0, 3'b000, 32'h80FF_0011, 1, 32'hFFFF_FF80);
        issue(1'b1, 2'd1, 5'd8, 32'h0000_2002, 32'h0, 3'b101, 32'hBEEF_1234, 0, 32'h0000_BEEF);
        issue(1'b1, 2'd1, 5'd9, 32'h0000_2000, 32'h0, 3'b001, 32'h0000_8001, 2, 32'hFFFF_8001);
        issue(1'b1, 2'd1, 5'd10, 32'h0000_3001, 32'h0, 3'b010, 32'hCAFE_F00D, 0, 32'hCAFE_F00D);
        issue(1'b1, 2'd2, 5'd0, 32'hDEAD_0000, 32'h0000_0100, 3'd0, 32'h0, 0, 32'h0000_0100);
        issue(1'b1, 2'd2, 5'd1, 32'hDEAD_0000, 32'h0000_0100, 3'd0, 32'h0, 0, 32'h0000_0100);
        issue(1'b1, 2'd0, 5'd11, 32'h1111_1111, 32'h0, 3'd0, 32'h0, 0, 32'h1111_1111);
        issue(1'b1, 2'd3, 5'd12, 32'h2222_2222, 32'h0, 3'd0, 32'h0, 0, 32'h2222_2222);
        issue(1'b1, 2'd0, 5'd13, 32'h3333_3333, 32'h0, 3'd0, 32'h0, 0, 32'h3333_3333);
        idle(3, 1'b1);

        // Reset while a load is outstanding.
        ifc.m_valid = 1'b1;
        ifc.m_reg_write = 1'b1;
        ifc.m_wb_sel = 2'd1;
        ifc.m_rd_index = 5'd14;
        ifc.m_funct3 = 3'b010;
        wait_accept();
        ifc.m_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_instret = 64'd0;
        #1;
        chk("midrst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("midrst_wb_data", {32'd0, wb_data}, 64'd0);
        chk("midrst_rd", {59'd0, W_rd_index}, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        chk("midrst_ready", {63'd0, ifc.m_ready}, 64'd0);
        chk("midrst_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2, 1'b1);
        idle(1, 1'b0);

        for (int k = 0; k < 300; k++) begin
            logic [1:0]  sel;
            logic [2:0]  f3;
            logic [31:0] alu, pc4, rdata;
            logic [4:0]  rd;
            logic        rw;
            sel   = 2'($urandom_range(0, 3));
            f3    = 3'($urandom_range(0, 7));
            alu   = $urandom;
            pc4   = $urandom;
            rdata = $urandom;
            rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rw    = ($urandom_range(0, 4) != 0);
            if (sel == 2'd1)
                issue(rw, sel, rd, alu, pc4, f3, rdata, $urandom_range(0, 3), model_load(f3, alu[1:0], rdata));
            else
                issue(rw, sel, rd, alu, pc4, f3, rdata, 0, (sel == 2'd2) ? pc4 : alu);
            if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        end
        idle(3, 1'b0);
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        chk("final_instret", instret, exp_instret);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
